// File: rtl/seven_seg_bcd_display.sv
// Binary to BCD (double-dabble, one bit per clock) to active-low seven-segment patterns.
// Optional macro SEVEN_SEG_BLINK_EN adds i_blink and a BLINK_DIV-bit divider that blanks o_seven.
module seven_seg_bcd_display #(
    parameter int IN_WIDTH = 6,
    parameter int N_DIGITS = 2
`ifdef SEVEN_SEG_BLINK_EN
    ,
    parameter int BLINK_DIV = 24
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [IN_WIDTH-1:0]   i_value,
    input  logic                  i_lz_blank,
`ifdef SEVEN_SEG_BLINK_EN
    input  logic                  i_blink,
`endif
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic [7*N_DIGITS-1:0] o_seven
);

    // BCD digit count: ceil(IN_WIDTH*0.302 + 1), done in integer arithmetic.
    localparam int BCD_DIGITS = (IN_WIDTH * 302 + 1999) / 1000;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int EXT_DIGITS = (BCD_DIGITS > N_DIGITS) ? BCD_DIGITS : N_DIGITS;
    localparam int EXT_W      = 4 * EXT_DIGITS;
    localparam int CNT_W      = $clog2(IN_WIDTH + 1);
    localparam int SEG_W      = 7 * N_DIGITS;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

    state_t                    state_q, state_d;
    logic [IN_WIDTH-1:0]       value_q, value_d;
    logic [BCD_W-1:0]          bcd_q, bcd_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      lz_q, lz_d;
    logic [SEG_W-1:0]          seven_q, seven_d;
    logic                      ovf_q, ovf_d;
    logic                      done_q, done_d;

    logic [BCD_W+IN_WIDTH-1:0] shift_cat;
    logic [EXT_W-1:0]          bcd_ext;
    logic [SEG_W-1:0]          disp_pat;
    logic                      disp_ovf;
    logic                      leading;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1011000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Digits beyond the display width force overflow; blanking walks down from the top digit.
    always_comb begin
        bcd_ext  = EXT_W'(bcd_q);
        disp_ovf = 1'b0;
        for (int k = N_DIGITS; k < EXT_DIGITS; k++) begin
            if (bcd_ext[4*k +: 4] != 4'd0) disp_ovf = 1'b1;
        end
        leading  = lz_q;
        disp_pat = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            if (bcd_ext[4*k +: 4] != 4'd0 || k == 0) leading = 1'b0;
            if (disp_ovf)     disp_pat[7*k +: 7] = SEG_DASH;
            else if (leading) disp_pat[7*k +: 7] = SEG_BLANK;
            else              disp_pat[7*k +: 7] = seg_of(bcd_ext[4*k +: 4]);
        end
    end

    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        lz_d      = lz_q;
        seven_d   = seven_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        shift_cat = '0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    value_d = i_value;
                    lz_d    = i_lz_blank;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_cat = {add3(bcd_q), value_q} << 1;
                bcd_d     = shift_cat[BCD_W+IN_WIDTH-1:IN_WIDTH];
                value_d   = shift_cat[IN_WIDTH-1:0];
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(IN_WIDTH - 1)) state_d = OUT;
            end
            OUT: begin
                seven_d = disp_pat;
                ovf_d   = disp_ovf;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            value_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            lz_q    <= 1'b0;
            seven_q <= {N_DIGITS{SEG_ZERO}};
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            lz_q    <= lz_d;
            seven_q <= seven_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign o_busy     = (state_q != IDLE);
    assign o_done     = done_q;
    assign o_overflow = ovf_q;

`ifdef SEVEN_SEG_BLINK_EN
    logic [BLINK_DIV-1:0] blink_cnt_q;
    logic                 blink_phase_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_DIV'(1);
            if (&blink_cnt_q) blink_phase_q <= ~blink_phase_q;
        end
    end

    assign o_seven = (i_blink && blink_phase_q) ? {SEG_W{1'b1}} : seven_q;
`else
    assign o_seven = seven_q;
`endif

endmodule

// File: tb/tb_seven_seg_bcd_display.sv
// Directed self-checking bench for seven_seg_bcd_display: defaults (6,2), an (8,2) overflow
// instance, and a blink instance when SEVEN_SEG_BLINK_EN is defined.
module tb_seven_seg_bcd_display;

    localparam logic [13:0] RST_PAT  = 14'b1000000_1000000;
    localparam logic [13:0] DASH_PAT = 14'b0111111_0111111;

    localparam int NA = 6;
    localparam logic [7:0]  VAL_A [NA] = '{8'd37, 8'd5, 8'd0, 8'd0, 8'd63, 8'd10};
    localparam logic        LZ_A  [NA] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam logic [13:0] EXP_A [NA] = '{
        14'b0110000_1011000,   // 37
        14'b1111111_0010010,   // 5, blanked
        14'b1111111_1000000,   // 0, blanked
        14'b1000000_1000000,   // 0
        14'b0000010_0110000,   // 63
        14'b1111001_1000000    // 10, blanked (no leading zero)
    };

    localparam int NB = 3;
    localparam logic [7:0]  VAL_B [NB] = '{8'd150, 8'd99, 8'd100};
    localparam logic [13:0] EXP_B [NB] = '{DASH_PAT, 14'b0010000_0010000, DASH_PAT};
    localparam logic        OVF_B [NB] = '{1'b1, 1'b0, 1'b1};

    logic        clk;
    logic        rst;
    logic [7:0]  value;
    logic        lz_blank;
    logic        valid_a, busy_a, done_a, ovf_a;
    logic [13:0] seven_a;
    logic        valid_b, busy_b, done_b, ovf_b;
    logic [13:0] seven_b;

    int checks;
    int failures;

    seven_seg_bcd_display #(.IN_WIDTH(6), .N_DIGITS(2)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_a), .i_value(value[5:0]),
        .i_lz_blank(lz_blank),
`ifdef SEVEN_SEG_BLINK_EN
        .i_blink(1'b0),
`endif
        .o_busy(busy_a), .o_done(done_a), .o_overflow(ovf_a), .o_seven(seven_a)
    );

    seven_seg_bcd_display #(.IN_WIDTH(8), .N_DIGITS(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_b), .i_value(value),
        .i_lz_blank(lz_blank),
`ifdef SEVEN_SEG_BLINK_EN
        .i_blink(1'b0),
`endif
        .o_busy(busy_b), .o_done(done_b), .o_overflow(ovf_b), .o_seven(seven_b)
    );

`ifdef SEVEN_SEG_BLINK_EN
    logic        valid_c, busy_c, done_c, ovf_c, blink;
    logic [13:0] seven_c;

    seven_seg_bcd_display #(.IN_WIDTH(6), .N_DIGITS(2), .BLINK_DIV(3)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_c), .i_value(value[5:0]),
        .i_lz_blank(lz_blank), .i_blink(blink),
        .o_busy(busy_c), .o_done(done_c), .o_overflow(ovf_c), .o_seven(seven_c)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic sel_done(input int which);
        case (which)
            0: return done_a;
            1: return done_b;
`ifdef SEVEN_SEG_BLINK_EN
            2: return done_c;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic sel_busy(input int which);
        case (which)
            0: return busy_a;
            1: return busy_b;
`ifdef SEVEN_SEG_BLINK_EN
            2: return busy_c;
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_valid(input int which, input logic v);
        case (which)
            0: valid_a = v;
            1: valid_b = v;
`ifdef SEVEN_SEG_BLINK_EN
            2: valid_c = v;
`endif
            default: ;
        endcase
    endtask

    // Returns the number of edges from the accepting edge to the one raising o_done,
    // and the number of cycles o_busy was seen high in between.
    task automatic convert(input int which, input logic [7:0] v, input logic lz,
                           output int lat, output int busy_cyc);
        @(negedge clk);
        value    = v;
        lz_blank = lz;
        set_valid(which, 1'b1);
        @(negedge clk);
        set_valid(which, 1'b0);
        lat      = 0;
        busy_cyc = 0;
        while (!sel_done(which) && lat < 40) begin
            if (sel_busy(which)) busy_cyc++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bcyc, dones;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        valid_a  = 1'b0;
        valid_b  = 1'b0;
        value    = '0;
        lz_blank = 1'b0;
`ifdef SEVEN_SEG_BLINK_EN
        valid_c  = 1'b0;
        blink    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_seven", seven_a, RST_PAT);
        check("rst_busy",  busy_a,  1'b0);
        check("rst_done",  done_a,  1'b0);
        check("rst_ovf",   ovf_a,   1'b0);

        for (int i = 0; i < NA; i++) begin
            convert(0, VAL_A[i], LZ_A[i], lat, bcyc);
            check($sformatf("a%0d_lat", i),   lat,     7);
            check($sformatf("a%0d_busy", i),  bcyc,    7);
            check($sformatf("a%0d_seven", i), seven_a, EXP_A[i]);
            check($sformatf("a%0d_ovf", i),   ovf_a,   1'b0);
            @(negedge clk);
            check($sformatf("a%0d_done_pulse", i), done_a, 1'b0);
            check($sformatf("a%0d_hold", i), seven_a, EXP_A[i]);
        end

        // Second request while busy must be dropped.
        @(negedge clk);
        value   = 8'd12;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        repeat (2) @(negedge clk);
        value   = 8'd40;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            if (done_a) dones++;
            @(negedge clk);
        end
        check("drop_dones", dones,   1);
        check("drop_seven", seven_a, 14'b1111001_0100100);
        check("drop_idle",  busy_a,  1'b0);

        for (int i = 0; i < NB; i++) begin
            convert(1, VAL_B[i], 1'b0, lat, bcyc);
            check($sformatf("b%0d_lat", i),   lat,     9);
            check($sformatf("b%0d_seven", i), seven_b, EXP_B[i]);
            check($sformatf("b%0d_ovf", i),   ovf_b,   OVF_B[i]);
        end

`ifdef SEVEN_SEG_BLINK_EN
        begin
            logic [13:0] s [24];
            int first, same;
            convert(2, 8'd21, 1'b0, lat, bcyc);
            check("c_seven", seven_c, 14'b0100100_1111001);
            same = 0;
            for (int c = 0; c < 10; c++) begin
                if (seven_c === 14'b0100100_1111001) same++;
                @(negedge clk);
            end
            check("c_steady", same, 10);
            blink = 1'b1;
            for (int c = 0; c < 24; c++) begin
                s[c] = seven_c;
                @(negedge clk);
            end
            first = 0;
            for (int c = 9; c >= 1; c--) if (s[c] !== s[c-1]) first = c;
            check("c_toggle_found", (first != 0), 1'b1);
            same = 0;
            for (int c = 0; c < 8; c++) if (s[first+c] === s[first]) same++;
            check("c_run_len", same, 8);
            check("c_run_end", (s[first+8] !== s[first]), 1'b1);
            check("c_pair", ((s[first] === 14'h3fff && s[first+8] === 14'b0100100_1111001) ||
                             (s[first+8] === 14'h3fff && s[first] === 14'b0100100_1111001)), 1'b1);
            blink = 1'b0;
            @(negedge clk);
            check("c_unblink", seven_c, 14'b0100100_1111001);
        end
`endif

        // Reset during a conversion of 63: immediate reset values, no o_done afterwards.
        @(negedge clk);
        value   = 8'd63;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_seven", seven_a, RST_PAT);
        check("abort_busy",  busy_a,  1'b0);
        check("abort_ovf",   ovf_a,   1'b0);
        check("abort_done",  done_a,  1'b0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            if (done_a) dones++;
            @(negedge clk);
        end
        check("abort_no_done",  dones,   0);
        check("abort_hold",     seven_a, RST_PAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg_bcd_display.md
Name: seven_seg_bcd_display

Overview:
- Parametrised, sequential successor to the fixed 2-digit seven-segment lookup decoder.
- Accepts an IN_WIDTH-bit unsigned binary value through a valid/busy handshake.
- Converts it to N_DIGITS BCD digits with an iterative shift-add-3 (double-dabble) engine, one bit per cycle.
- Registers active-low segment patterns for every digit; supports leading-zero blanking and overflow indication. Drives DE2-115 HEX displays from any counter/status value.

Parameters:
- IN_WIDTH, 6, width of the binary input value (1..20).
- N_DIGITS, 2, number of decimal digits driven (1..8); digit 0 is least significant.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  request to convert i_value; accepted only when o_busy=0.
- i_value  in  IN_WIDTH  unsigned binary value.
- i_lz_blank  in  1  leading-zero blanking enable, sampled at accept.
- o_busy  out  1  conversion in progress (state != IDLE).
- o_done  out  1  one-cycle pulse in the cycle the new o_seven is valid.
- o_overflow  out  1  registered; 1 if the last accepted value exceeded 10^N_DIGITS-1.
- o_seven  out  7*N_DIGITS  segment patterns, digit k at bits [7k+6:7k], active-low (1 = dark).

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Segment map, bit index = segment: 0 top, 1 upper-right, 2 lower-right, 3 bottom, 4 lower-left, 5 upper-left, 6 middle.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1011000, 8=0000000, 9=0010000
  - BLANK=1111111, DASH=0111111
- Reset values: state IDLE; o_busy=0; o_done=0; o_overflow=0; every digit of o_seven = pattern 0 (1000000); internal shift/BCD registers cleared.
- FSM states: IDLE, SHIFT, OUT.
  - IDLE: at an edge with i_valid=1, latch i_value and i_lz_blank, clear the BCD accumulator, set bit counter=0, go to SHIFT.
  - SHIFT: each edge, add 3 to every BCD nibble >=5, then shift {BCD, value} left by 1. Increment the counter. After the IN_WIDTH-th shift, go to OUT.
  - OUT: at the next edge, load o_seven and o_overflow, assert o_done for exactly one cycle, return to IDLE.
- Latency: IN_WIDTH+1 edges from the accepting edge to the edge that updates o_seven and raises o_done. Default is 7.
- o_busy is combinational from state: high in SHIFT and OUT (IN_WIDTH+1 cycles). A new request can be accepted in the cycle o_done is high.
- i_valid while o_busy=1 is ignored and dropped, not queued. i_value is not required stable after acceptance.
- Internal BCD accumulator width: 4*ceil(IN_WIDTH*0.302+1) bits, enough for the full input range.
- Overflow: value > 10^N_DIGITS-1 (including any nonzero BCD digit at index >= N_DIGITS) gives o_overflow=1 and all digits = DASH. Otherwise o_overflow=0.
- Leading-zero blanking (when latched i_lz_blank=1 and no overflow): digits above the most significant nonzero digit show BLANK. Digit 0 is never blanked, so value 0 displays "0".
- o_seven holds its value between conversions. It changes only in OUT or on reset.
- Reset asserted mid-conversion: immediate return to the reset values; no o_done for the aborted request.

Optional Feature:
- Macro SEVEN_SEG_BLINK_EN.
- When defined:
  - Adds parameter BLINK_DIV (default 24) and input port i_blink (1 bit).
  - A free-running BLINK_DIV-bit counter, reset to 0, toggles a phase bit on wrap.
  - While i_blink=1 and the phase bit is 1, o_seven outputs all BLANK. Otherwise it outputs the registered patterns.
  - Masking is combinational on the output only; stored patterns, o_done and the handshake are unaffected.
- When not defined: no port, no counter; o_seven is driven directly from the registered patterns.

Test Plan:
- Reset then idle -> o_seven=1000000_1000000, o_busy=0, o_done=0, o_overflow=0.
- Defaults (6,2), i_value=37, i_lz_blank=0, one-cycle i_valid -> o_busy high 7 cycles; o_done pulse on the 7th edge after accept; o_seven={0110000 (3),1011000 (7)}.
- Defaults, i_value=5 with i_lz_blank=1 -> {1111111,0010010}. Then i_value=0 with i_lz_blank=1 -> {1111111,1000000}.
- IN_WIDTH=8, N_DIGITS=2, i_value=150 -> o_overflow=1, both digits 0111111. Then 99 -> o_overflow=0, {0010000,0010000}.
- Defaults: accept 12, pulse i_valid with 40 at cycle 3 while busy -> 40 dropped, final display 12, exactly one o_done. Assert i_rst at cycle 4 of a new conversion of 63 -> reset values, no o_done.
- SEVEN_SEG_BLINK_EN with BLINK_DIV=3, i_blink=1, value 21 displayed -> o_seven alternates between {0100100,1111001} and all-1s every 8 cycles. i_blink=0 -> steady.
